// File: rtl/mvb_sched_pkg.sv
// MVB frame scheduler shared types: FSM states, frame type codes,
// default timing constants, s_len legality and saturating increment.
package mvb_sched_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 7;
  localparam int CNT_W  = 16;

  localparam int SEND_HOLD_DEF = 32;
  localparam int TIMEOUT_DEF   = 4096;
  localparam int GAP_DEF       = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_e;

  typedef enum logic {
    FT_M = 1'b0,
    FT_S = 1'b1
  } ftype_e;

  function automatic logic len_ok(
    input logic [LEN_W-1:0] l
  );
    return (l == 7'd1) || (l == 7'd2) ||
           (l == 7'd4) || (l == 7'd8) ||
           (l == 7'd16);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mvb_frame_scheduler_if.sv
// Requester/encoder bus of the MVB frame scheduler.
// master: scheduler side (m_*/s_* requesters, enc_* encoder); slave: peers.
interface mvb_frame_scheduler_if;
  import mvb_sched_pkg::*;

  logic              m_req;
  logic [DATA_W-1:0] m_data;
  logic              m_ack;
  logic              s_req;
  logic [LEN_W-1:0]  s_len;
  logic              s_rd_en;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_ack;
  logic              enc_wr_en;
  logic [DATA_W-1:0] enc_wr_data;
  logic [LEN_W-1:0]  enc_frame_length;
  logic              enc_M_frame;
  logic              enc_S_frame;
  logic              enc_send_frame;
  logic              enc_frame_over;

  modport master (
    input  m_req, m_data, s_req, s_len,
    input  s_rd_data, enc_frame_over,
    output m_ack, s_ack, s_rd_en,
    output enc_wr_en, enc_wr_data,
    output enc_frame_length,
    output enc_M_frame, enc_S_frame,
    output enc_send_frame
  );

  modport slave (
    output m_req, m_data, s_req, s_len,
    output s_rd_data, enc_frame_over,
    input  m_ack, s_ack, s_rd_en,
    input  enc_wr_en, enc_wr_data,
    input  enc_frame_length,
    input  enc_M_frame, enc_S_frame,
    input  enc_send_frame
  );

endinterface

// File: rtl/mvb_rr_arbiter.sv
// 2-way round-robin arbiter: clk, rst (sync, low), req[1:0] (0=M, 1=S),
// advance; grant[1:0] one-hot. Pointer moves to the loser after a grant.
module mvb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mvb_frame_scheduler.sv
// Shares the MVB encoder between master (M) and slave (S) frame sources.
// Ports: clk, rst (sync, low), bus (master modport), busy, err_timeout,
// err_len, stat_*_cnt (live only with MVB_SCHED_STATS_EN defined).
module mvb_frame_scheduler
  import mvb_sched_pkg::*;
#(
  parameter int SEND_HOLD   = SEND_HOLD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int GAP_CYC     = GAP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mvb_frame_scheduler_if.master bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_len,
  output logic [15:0]          stat_m_cnt,
  output logic [15:0]          stat_s_cnt,
  output logic [15:0]          stat_to_cnt
);

  state_e           state_q, state_d;
  ftype_e           type_q, type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_q, fo_q;
  logic [1:0]       req, gnt;
  logic             rd_en, m_ack, s_ack;
  logic             fo_rise, tmo, m_load, in_frm;

  // no grants while in reset so nothing pulses combinationally
  assign req = {bus.s_req, bus.m_req}
             & {2{rst && state_q == ST_IDLE}};

  mvb_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (|gnt),
    .grant   (gnt)
  );

  assign fo_rise = bus.enc_frame_over & ~fo_q;
  assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYC);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rd_en       = 1'b0;
    m_ack       = 1'b0;
    s_ack       = 1'b0;
    err_len     = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gnt[0]) begin
          type_d  = FT_M;
          len_d   = 7'd1;
          state_d = ST_LOAD;
        end else if (gnt[1]) begin
          if (len_ok(bus.s_len)) begin
            type_d  = FT_S;
            len_d   = bus.s_len;
            state_d = ST_LOAD;
          end else begin
            err_len = 1'b1;
            s_ack   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (type_q == FT_M) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end else begin
          // cnt_q counts reads; writes trail by one cycle
          rd_en = cnt_q < CNT_W'(len_q);
          if (rd_en) cnt_d = sat_inc(cnt_q);
          if (wr_q && !rd_en) begin
            state_d = ST_SEND;
            cnt_d   = '0;
          end
        end
      end
      ST_SEND: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == CNT_W'(SEND_HOLD - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        // an edge in the timeout cycle still counts as success
        if (fo_rise || tmo) begin
          m_ack       = type_q == FT_M;
          s_ack       = type_q == FT_S;
          err_timeout = !fo_rise;
          state_d     = ST_GAP;
          cnt_d       = '0;
        end
      end
      ST_GAP: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      type_q  <= FT_M;
      cnt_q   <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      fo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wr_q    <= rd_en;
      fo_q    <= bus.enc_frame_over;
    end
  end

  assign m_load = state_q == ST_LOAD && type_q == FT_M;
  assign in_frm = state_q == ST_LOAD ||
                  state_q == ST_SEND ||
                  state_q == ST_WAIT;

  assign bus.s_rd_en     = rd_en;
  assign bus.m_ack       = m_ack;
  assign bus.s_ack       = s_ack;
  assign bus.enc_wr_en   = m_load | wr_q;
  assign bus.enc_wr_data = m_load ? bus.m_data :
                           wr_q   ? bus.s_rd_data : '0;
  assign bus.enc_frame_length = in_frm ? len_q : '0;
  assign bus.enc_M_frame = in_frm && type_q == FT_M;
  assign bus.enc_S_frame = in_frm && type_q == FT_S;
  assign bus.enc_send_frame = state_q == ST_SEND;
  assign busy = state_q != ST_IDLE;

`ifdef MVB_SCHED_STATS_EN
  logic [15:0] sm_q, ss_q, st_q;
  logic        ok_m, ok_s;

  assign ok_m = m_ack && !err_timeout;
  assign ok_s = s_ack && !err_timeout && !err_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sm_q <= '0;
      ss_q <= '0;
      st_q <= '0;
    end else begin
      if (ok_m && !(&sm_q)) sm_q <= sm_q + 1'b1;
      if (ok_s && !(&ss_q)) ss_q <= ss_q + 1'b1;
      if (err_timeout && !(&st_q))
        st_q <= st_q + 1'b1;
    end
  end

  assign stat_m_cnt  = sm_q;
  assign stat_s_cnt  = ss_q;
  assign stat_to_cnt = st_q;
`else
  assign stat_m_cnt  = '0;
  assign stat_s_cnt  = '0;
  assign stat_to_cnt = '0;
`endif

endmodule

// File: tb/tb_mvb_frame_scheduler.sv
// Directed self-checking bench for mvb_frame_scheduler.
// Drives the bus interface, models the slave buffer and frame_over.
module tb_mvb_frame_scheduler;

`ifdef MVB_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy, err_timeout, err_len;
  logic [15:0] stat_m_cnt, stat_s_cnt, stat_to_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] sbuf [16];
  logic [3:0]  sb_ptr;
  logic        sb_clr;

  int   sn, wn;
  logic ma, sa, eto;
  bit   ok;

  mvb_frame_scheduler_if bus();

  mvb_frame_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_len     (err_len),
    .stat_m_cnt  (stat_m_cnt),
    .stat_s_cnt  (stat_s_cnt),
    .stat_to_cnt (stat_to_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sb_clr) sb_ptr <= '0;
    else if (bus.s_rd_en) begin
      bus.s_rd_data <= sbuf[sb_ptr];
      sb_ptr <= sb_ptr + 1'b1;
    end
  end

  // follow one frame from SEND to its ack; fo_delay<0: no frame_over
  task automatic run_to_ack(input int fo_delay);
    ok = 0; sn = 0; wn = 0;
    ma = 0; sa = 0; eto = 0;
    for (int i = 0; i < 100 && !bus.enc_send_frame; i++)
      @(negedge clk);
    if (!bus.enc_send_frame) return;
    while (bus.enc_send_frame && sn < 100) begin
      sn++;
      @(negedge clk);
    end
    for (int k = 0; k < 5000; k++) begin
      if (k == fo_delay) bus.enc_frame_over = 1'b1;
      #1;
      if (bus.m_ack || bus.s_ack) begin
        ma = bus.m_ack; sa = bus.s_ack;
        eto = err_timeout; wn = k; ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drop_and_idle(output int n);
    @(posedge clk); #1;
    bus.m_req = 0; bus.s_req = 0;
    bus.enc_frame_over = 0;
    n = 1;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 0; sb_clr = 1;
    bus.m_req = 0; bus.m_data = '0;
    bus.s_req = 0; bus.s_len = '0;
    bus.enc_frame_over = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if ({bus.enc_wr_en, bus.enc_send_frame,
         bus.s_rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b%b%b want 000",
               bus.enc_wr_en, bus.enc_send_frame,
               bus.s_rd_en);
    end
    checks++;
    if ({bus.m_ack, bus.s_ack, err_len,
         err_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses got %b%b%b%b want 0000",
               bus.m_ack, bus.s_ack, err_len, err_timeout);
    end
    checks++;
    if ({bus.enc_M_frame, bus.enc_S_frame,
         bus.enc_frame_length} !== 9'd0) begin
      errors++;
      $display("FAIL reset_frame got %b %b %0d want 0 0 0",
               bus.enc_M_frame, bus.enc_S_frame,
               bus.enc_frame_length);
    end
    @(negedge clk);
    rst = 1; sb_clr = 0;
    n = 0;
  endtask

  task automatic test_master();
    int n;
    @(negedge clk);
    bus.m_req = 1; bus.m_data = 16'h7EC3;
    @(negedge clk); #1;
    checks++;
    if (bus.enc_wr_en !== 1'b1 ||
        bus.enc_wr_data !== 16'h7EC3) begin
      errors++;
      $display("FAIL m_write got en=%b d=%h want 1 7ec3",
               bus.enc_wr_en, bus.enc_wr_data);
    end
    checks++;
    if (bus.enc_M_frame !== 1'b1 ||
        bus.enc_S_frame !== 1'b0 ||
        bus.enc_frame_length !== 7'd1) begin
      errors++;
      $display("FAIL m_type got M=%b S=%b len=%0d want 1 0 1",
               bus.enc_M_frame, bus.enc_S_frame,
               bus.enc_frame_length);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.enc_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL m_single_write got %b want 0",
               bus.enc_wr_en);
    end
    run_to_ack(500);
    checks++;
    if (!ok || sn != 32) begin
      errors++;
      $display("FAIL m_send_hold got ok=%0d n=%0d want 1 32",
               ok, sn);
    end
    checks++;
    if (wn != 500 || ma !== 1'b1 || sa !== 1'b0 ||
        eto !== 1'b0) begin
      errors++;
      $display("FAIL m_ack got k=%0d m=%b s=%b to=%b want 500 1 0 0",
               wn, ma, sa, eto);
    end
    drop_and_idle(n);
    checks++;
    if (n != 65) begin
      errors++;
      $display("FAIL m_gap got %0d want 65", n);
    end
  endtask

  task automatic test_illegal_len();
    bit bad;
    @(negedge clk);
    bus.s_len = 7'd3; bus.s_req = 1; #1;
    checks++;
    if (err_len !== 1'b1 || bus.s_ack !== 1'b1 ||
        bus.m_ack !== 1'b0) begin
      errors++;
      $display("FAIL len_reject got el=%b sa=%b ma=%b want 1 1 0",
               err_len, bus.s_ack, bus.m_ack);
    end
    @(posedge clk); #1;
    bus.s_req = 0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.enc_wr_en || bus.enc_send_frame ||
          busy || err_len || bus.s_rd_en) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL len_idle got activity=1 want 0");
    end
  endtask

  task automatic test_round_robin();
    int n, ack_c;
    logic exp_m;
    ack_c = 0;
    @(negedge clk);
    bus.s_len = 7'd2; bus.m_data = 16'hA5A5;
    bus.m_req = 1; bus.s_req = 1;
    for (int i = 0; i < 4; i++) begin
      exp_m = (i % 2) == 0;
      n = 0;
      while (!bus.enc_wr_en && n < 300) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.enc_M_frame !== exp_m ||
          bus.enc_S_frame !== !exp_m) begin
        errors++;
        $display("FAIL rr_grant%0d got M=%b S=%b want M=%b",
                 i, bus.enc_M_frame, bus.enc_S_frame, exp_m);
      end
      if (i > 0) begin
        checks++;
        if (cyc - ack_c < 65) begin
          errors++;
          $display("FAIL rr_gap%0d got %0d want >=65",
                   i, cyc - ack_c);
        end
      end
      run_to_ack(10);
      checks++;
      if (!ok || ma !== exp_m || sa !== !exp_m) begin
        errors++;
        $display("FAIL rr_ack%0d got ok=%0d m=%b s=%b want m=%b",
                 i, ok, ma, sa, exp_m);
      end
      ack_c = cyc;
      @(posedge clk); #1;
      bus.enc_frame_over = 0;
    end
    drop_and_idle(n);
  endtask

  task automatic test_slave();
    int n, idx, rdn, wcnt, first_w;
    logic [15:0] wdat [8];
    bit tbad, dbad;
    @(negedge clk);
    sb_clr = 1; bus.s_len = 7'd4; bus.s_req = 1;
    @(negedge clk);
    sb_clr = 0;
    idx = 1; rdn = 0; wcnt = 0; first_w = -1;
    tbad = 0;
    while (!bus.enc_send_frame && idx < 40) begin
      if (bus.s_rd_en) rdn++;
      if (bus.enc_wr_en) begin
        if (first_w < 0) first_w = idx;
        if (wcnt < 8) wdat[wcnt] = bus.enc_wr_data;
        wcnt++;
        if (bus.enc_S_frame !== 1'b1 ||
            bus.enc_M_frame !== 1'b0 ||
            bus.enc_frame_length !== 7'd4) tbad = 1;
      end
      @(negedge clk);
      idx++;
    end
    checks++;
    if (rdn != 4 || wcnt != 4) begin
      errors++;
      $display("FAIL s_counts got rd=%0d wr=%0d want 4 4",
               rdn, wcnt);
    end
    checks++;
    if (first_w != 2) begin
      errors++;
      $display("FAIL s_latency got %0d want 2", first_w);
    end
    dbad = 0;
    for (int i = 0; i < 4; i++)
      if (wdat[i] !== 16'(i + 1)) dbad = 1;
    checks++;
    if (dbad) begin
      errors++;
      $display("FAIL s_data got %h %h %h %h want 1 2 3 4",
               wdat[0], wdat[1], wdat[2], wdat[3]);
    end
    checks++;
    if (tbad) begin
      errors++;
      $display("FAIL s_type got bad=1 want S=1 M=0 len=4");
    end
    run_to_ack(20);
    checks++;
    if (!ok || sn != 32 || wn != 20 ||
        sa !== 1'b1 || ma !== 1'b0) begin
      errors++;
      $display("FAIL s_ack got ok=%0d n=%0d k=%0d s=%b m=%b",
               ok, sn, wn, sa, ma);
    end
    drop_and_idle(n);
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk);
    bus.m_req = 1; bus.m_data = 16'h0F0F;
    run_to_ack(-1);
    checks++;
    if (!ok || wn != 4096 || ma !== 1'b1 ||
        eto !== 1'b1) begin
      errors++;
      $display("FAIL timeout got ok=%0d k=%0d m=%b to=%b want 4096",
               ok, wn, ma, eto);
    end
    drop_and_idle(n);
    checks++;
    if (stat_to_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL stat_to got %0d want %0d",
               stat_to_cnt, STATS ? 1 : 0);
    end
    checks++;
    if (stat_m_cnt !== (STATS ? 16'd3 : 16'd0) ||
        stat_s_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL stat_ms got %0d %0d want %0d",
               stat_m_cnt, stat_s_cnt, STATS ? 3 : 0);
    end
  endtask

  task automatic test_reset_in_load();
    int n;
    bit ackd;
    @(negedge clk);
    sb_clr = 1; bus.s_len = 7'd16; bus.s_req = 1;
    @(negedge clk);
    sb_clr = 0;
    @(negedge clk);
    @(negedge clk);
    ackd = bus.s_ack;
    rst = 0; bus.s_req = 0;
    @(negedge clk); #1;
    ackd = ackd | bus.s_ack;
    checks++;
    if (busy !== 1'b0 || bus.s_rd_en !== 1'b0 ||
        bus.enc_wr_en !== 1'b0 || ackd) begin
      errors++;
      $display("FAIL rst_load got b=%b rd=%b wr=%b ack=%0d",
               busy, bus.s_rd_en, bus.enc_wr_en, ackd);
    end
    checks++;
    if (bus.enc_frame_length !== 7'd0 ||
        bus.enc_S_frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame got len=%0d S=%b want 0 0",
               bus.enc_frame_length, bus.enc_S_frame);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    bus.m_req = 1; bus.m_data = 16'h1234;
    @(negedge clk); #1;
    checks++;
    if (bus.enc_wr_en !== 1'b1 ||
        bus.enc_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL post_rst_write got en=%b d=%h want 1 1234",
               bus.enc_wr_en, bus.enc_wr_data);
    end
    run_to_ack(5);
    checks++;
    if (!ok || wn != 5 || ma !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ack got ok=%0d k=%0d m=%b",
               ok, wn, ma);
    end
    drop_and_idle(n);
    checks++;
    if (stat_m_cnt !== (STATS ? 16'd1 : 16'd0) ||
        stat_to_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_rst_stat got %0d %0d want %0d 0",
               stat_m_cnt, stat_to_cnt, STATS ? 1 : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sbuf[i] = 16'(i + 1);
    test_reset();
    test_master();
    test_illegal_len();
    test_round_robin();
    test_slave();
    test_timeout();
    test_reset_in_load();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
